// File: rtl/background_scroll_renderer.sv
// Background tile renderer with fine/coarse wrap-around scrolling, a 32x32
// nametable and a shadow register set that becomes active at frame_start.
// Ports: clk/rst (sync, active-low); xp/yp/in_valid pixel request;
//   frame_start loads active registers; writable/data/address/write_enable
//   VRAM byte bus; r/g/b/opaque/out_valid pixel result, fixed 3-cycle latency.
module background_scroll_renderer #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] PMB_BASE  = ADDR_W'(12'h200),
  parameter logic [ADDR_W-1:0] NTBL_BASE = ADDR_W'(12'h400),
  parameter logic [ADDR_W-1:0] REG_BASE  = ADDR_W'(12'h800)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        xp,
  input  logic [7:0]        yp,
  input  logic              in_valid,
  input  logic              frame_start,
  input  logic              writable,
  input  logic [7:0]        data,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_enable,
  output logic [1:0]        r,
  output logic [1:0]        g,
  output logic [1:0]        b,
  output logic              opaque,
  output logic              out_valid
);

  localparam logic [ADDR_W-1:0] PMB_SIZE  = ADDR_W'(512);
  localparam logic [ADDR_W-1:0] NTBL_SIZE = ADDR_W'(1024);
  localparam logic [ADDR_W-1:0] REG_SIZE  = ADDR_W'(4);

  // Address decode: unsigned offset below the window size means a hit, since
  // addresses under the base wrap to large offsets.
  logic [ADDR_W-1:0] pmb_off, ntbl_off, reg_off;
  logic              pmb_we, ntbl_we, reg_we;

  assign pmb_off  = address - PMB_BASE;
  assign ntbl_off = address - NTBL_BASE;
  assign reg_off  = address - REG_BASE;
  assign pmb_we   = write_enable && writable && (pmb_off < PMB_SIZE);
  assign ntbl_we  = write_enable && writable && (ntbl_off < NTBL_SIZE);
  assign reg_we   = write_enable && (reg_off < REG_SIZE);

  // Shadow and active register sets.
  logic [5:0] sh_colors, act_colors, colors_nx;
  logic [7:0] sh_scroll_x, act_scroll_x, scroll_x_nx;
  logic [7:0] sh_scroll_y, act_scroll_y, scroll_y_nx;
  logic       sh_enable, act_enable, enable_nx;

  // Next shadow value; the active set copies this so a write coinciding with
  // frame_start takes effect immediately.
  always_comb begin
    colors_nx   = sh_colors;
    scroll_x_nx = sh_scroll_x;
    scroll_y_nx = sh_scroll_y;
    enable_nx   = sh_enable;
    if (reg_we) begin
      case (reg_off[1:0])
        2'd0:    colors_nx   = data[5:0];
        2'd1:    scroll_x_nx = data;
        2'd2:    scroll_y_nx = data;
        default: enable_nx   = data[0];
      endcase
    end
  end

  // Pattern and nametable memories (no reset, synchronous read).
  logic [7:0] pmb  [512];
  logic [7:0] ntbl [1024];

  // S1: scrolled coordinates and nametable address.
  logic [7:0] sx, sy;
  logic [9:0] ntbl_addr;
  assign sx        = xp + act_scroll_x;
  assign sy        = yp + act_scroll_y;
  assign ntbl_addr = {sy[7:3], sx[7:3]};

  logic [7:0] tile;
  logic [2:0] s1_fx, s1_fy;
  logic       s1_vld;

  // S2: tile decode and pattern row address.
  logic [2:0] row;
  logic [8:0] pmb_addr0, pmb_addr1;
  assign row       = tile[5] ? (3'd7 - s1_fy) : s1_fy;
  assign pmb_addr0 = {tile[4:0], row, 1'b0};
  assign pmb_addr1 = {tile[4:0], row, 1'b1};

  logic [7:0] byte0, byte1;
  logic [2:0] s2_fx;
  logic       s2_hflip, s2_csel, s2_vld;

  // S3: pixel select and colour.
  logic [15:0] line;
  logic [2:0]  idx;
  logic [1:0]  pix;
  logic [2:0]  color;
  assign line  = {byte0, byte1};
  assign idx   = s2_hflip ? (3'd7 - s2_fx) : s2_fx;
  assign pix   = line[{idx, 1'b0} +: 2];
  assign color = s2_csel ? act_colors[5:3] : act_colors[2:0];

  // Memory arrays and pipeline data path; read-during-write yields old data.
  always_ff @(posedge clk) begin
    if (pmb_we)  pmb[pmb_off[8:0]]   <= data;
    if (ntbl_we) ntbl[ntbl_off[9:0]] <= data;
    tile     <= ntbl[ntbl_addr];
    s1_fx    <= sx[2:0];
    s1_fy    <= sy[2:0];
    byte0    <= pmb[pmb_addr0];
    byte1    <= pmb[pmb_addr1];
    s2_fx    <= s1_fx;
    s2_hflip <= tile[6];
    s2_csel  <= tile[7];
  end

  // Control state: valid bits, registers and outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      out_valid    <= 1'b0;
      r            <= 2'd0;
      g            <= 2'd0;
      b            <= 2'd0;
      opaque       <= 1'b0;
      sh_colors    <= 6'd0;
      sh_scroll_x  <= 8'd0;
      sh_scroll_y  <= 8'd0;
      sh_enable    <= 1'b0;
      act_colors   <= 6'd0;
      act_scroll_x <= 8'd0;
      act_scroll_y <= 8'd0;
      act_enable   <= 1'b0;
    end else begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      if (s2_vld && act_enable) begin
        r      <= pix & {2{color[2]}};
        g      <= pix & {2{color[1]}};
        b      <= pix & {2{color[0]}};
        opaque <= (pix != 2'd0);
      end else begin
        r      <= 2'd0;
        g      <= 2'd0;
        b      <= 2'd0;
        opaque <= 1'b0;
      end
      sh_colors   <= colors_nx;
      sh_scroll_x <= scroll_x_nx;
      sh_scroll_y <= scroll_y_nx;
      sh_enable   <= enable_nx;
      if (frame_start) begin
        act_colors   <= colors_nx;
        act_scroll_x <= scroll_x_nx;
        act_scroll_y <= scroll_y_nx;
        act_enable   <= enable_nx;
      end
    end
  end

endmodule

// File: tb/tb_background_scroll_renderer.sv
module tb_background_scroll_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  xp = 8'd0, yp = 8'd0, data = 8'd0;
  logic [11:0] address = 12'd0;
  logic        in_valid = 1'b0, frame_start = 1'b0, writable = 1'b0, write_enable = 1'b0;
  logic [1:0]  r, g, b;
  logic        opaque, out_valid;

  always #5 clk = ~clk;

  background_scroll_renderer dut (
    .clk(clk), .rst(rst), .xp(xp), .yp(yp), .in_valid(in_valid),
    .frame_start(frame_start), .writable(writable), .data(data),
    .address(address), .write_enable(write_enable),
    .r(r), .g(g), .b(b), .opaque(opaque), .out_valid(out_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Reference model: memory images, register sets, in-flight pixels.
  logic [7:0] pmb_m  [512];
  logic [7:0] ntbl_m [1024];
  int sh_col = 0, sh_sx = 0, sh_sy = 0, sh_en = 0;
  int ac_col = 0, ac_sx = 0, ac_sy = 0, ac_en = 0;

  typedef struct {
    logic       vld;
    logic [1:0] p;
    logic       csel;
  } ent_t;
  ent_t q[$];

  bit         capture = 0;
  logic [1:0] cap_r[$];
  logic       cap_o[$];

  function automatic ent_t pix_model();
    ent_t e;
    int sx, sy, fx, fy, row, pat, i, line;
    logic [7:0] tile;
    e.vld = 1'b0; e.p = 2'd0; e.csel = 1'b0;
    if (!in_valid) return e;
    sx   = (int'(xp) + ac_sx) % 256;
    sy   = (int'(yp) + ac_sy) % 256;
    tile = ntbl_m[(sy / 8) * 32 + sx / 8];
    fx   = sx % 8;
    fy   = sy % 8;
    row  = tile[5] ? 7 - fy : fy;
    pat  = int'(tile) % 32;
    line = int'(pmb_m[pat * 16 + row * 2]) * 256 + int'(pmb_m[pat * 16 + row * 2 + 1]);
    i    = tile[6] ? 7 - fx : fx;
    e.vld  = 1'b1;
    e.p    = 2'((line >> (2 * i)) % 4);
    e.csel = tile[7];
    return e;
  endfunction

  // One clock: predict, apply the bus write to the model, advance, compare.
  task automatic tick();
    ent_t e, o;
    int c, a, er, eg, eb, eo;
    if (!rst) begin
      sh_col = 0; sh_sx = 0; sh_sy = 0; sh_en = 0;
      ac_col = 0; ac_sx = 0; ac_sy = 0; ac_en = 0;
      q.delete();
      q.push_back('{1'b0, 2'd0, 1'b0});
      q.push_back('{1'b0, 2'd0, 1'b0});
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rgb", {r, g, b}, 0);
      chk("rst_opaque", opaque, 0);
      return;
    end
    e = pix_model();
    q.push_back(e);
    o = q.pop_front();
    c  = o.csel ? (ac_col / 8) % 8 : ac_col % 8;
    er = (ac_en != 0 && (c & 4) != 0) ? int'(o.p) : 0;
    eg = (ac_en != 0 && (c & 2) != 0) ? int'(o.p) : 0;
    eb = (ac_en != 0 && (c & 1) != 0) ? int'(o.p) : 0;
    eo = (ac_en != 0 && o.p != 0) ? 1 : 0;
    if (write_enable) begin
      a = int'(address);
      if (writable && a >= 'h200 && a < 'h400) pmb_m[a - 'h200] = data;
      if (writable && a >= 'h400 && a < 'h800) ntbl_m[a - 'h400] = data;
      case (a)
        'h800: sh_col = int'(data) % 64;
        'h801: sh_sx  = int'(data);
        'h802: sh_sy  = int'(data);
        'h803: sh_en  = int'(data) % 2;
        default: ;
      endcase
    end
    if (frame_start) begin
      ac_col = sh_col; ac_sx = sh_sx; ac_sy = sh_sy; ac_en = sh_en;
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, o.vld);
    if (o.vld) begin
      chk("r", r, er);
      chk("g", g, eg);
      chk("b", b, eb);
      chk("opaque", opaque, eo);
      if (capture) begin
        cap_r.push_back(r);
        cap_o.push_back(opaque);
      end
    end else begin
      chk("idle_zero", {r, g, b, opaque}, 0);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; write_enable = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input int a, input int d, input bit wbl);
    in_valid = 1'b0; address = 12'(a); data = 8'(d);
    writable = wbl; write_enable = 1'b1;
    tick();
    write_enable = 1'b0; writable = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic px(input int x, input int y);
    in_valid = 1'b1; xp = 8'(x); yp = 8'(y);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cap_start();
    cap_r.delete(); cap_o.delete(); capture = 1;
  endtask

  // Compare captured r values with n 2-bit entries packed LSB first.
  task automatic cap_check(input string tag, input int n, input logic [15:0] exp_r);
    capture = 0;
    chk({tag, "_count"}, cap_r.size(), n);
    for (int i = 0; i < n && i < cap_r.size(); i++)
      chk(tag, cap_r[i], exp_r[2 * i +: 2]);
  endtask

  initial begin
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    idle(2);

    // Fill all pattern and nametable memory with random bytes.
    for (int i = 0; i < 1536; i++) wr('h200 + i, $urandom_range(0, 255), 1'b1);
    idle(3);

    // Unscrolled render.
    for (int rw = 0; rw < 8; rw++) begin
      wr('h210 + 2 * rw, 'hE4, 1'b1);
      wr('h211 + 2 * rw, 'hE4, 1'b1);
    end
    wr('h400, 'h01, 1'b1);
    wr('h800, 'b000_111, 1'b1);
    wr('h801, 0, 1'b1);
    wr('h802, 0, 1'b1);
    wr('h803, 1, 1'b1);
    fs();
    cap_start();
    for (int x = 0; x < 8; x++) px(x, 0);
    idle(3);
    cap_check("plain", 8, 16'hE4E4);

    // Horizontal flip.
    wr('h400, 'h41, 1'b1);
    idle(2);
    cap_start();
    for (int x = 0; x < 8; x++) px(x, 0);
    idle(3);
    cap_check("hflip", 8, 16'h1B1B);

    // Vertical flip: row 0 all ones, row 7 all zeros, fetched from yp = 7.
    wr('h210, 'h55, 1'b1); wr('h211, 'h55, 1'b1);
    wr('h21E, 'h00, 1'b1); wr('h21F, 'h00, 1'b1);
    wr('h421, 0, 1'b1);
    wr('h400, 'h21, 1'b1);
    idle(2);
    cap_start();
    for (int x = 0; x < 8; x++) px(x, 7);
    idle(3);
    cap_check("vflip", 8, 16'h5555);

    // Scroll wrap: tile (31,31) = pattern 2 (all 3s), (31,0) = pattern 3 (all 1s).
    wr('h220, 'hFF, 1'b1); wr('h221, 'hFF, 1'b1);
    wr('h230, 'h55, 1'b1); wr('h231, 'h55, 1'b1);
    wr('h400 + 1023, 'h02, 1'b1);
    wr('h400 + 992, 'h03, 1'b1);
    wr('h400 + 993, 'h03, 1'b1);
    wr('h801, 'hFC, 1'b1);
    wr('h802, 'hF8, 1'b1);
    fs();
    cap_start();
    px(2, 0); px(4, 0);
    idle(3);
    cap_check("wrap", 2, 16'h0007);

    // Shadow timing: a plain write is invisible; a write with frame_start is used at once.
    wr('h801, 8, 1'b1);
    cap_start();
    px(2, 0);
    idle(3);
    cap_check("shadow_hold", 1, 16'h0003);
    frame_start = 1'b1;
    wr('h801, 'hFE, 1'b1);
    frame_start = 1'b0;
    cap_start();
    px(0, 0);
    idle(3);
    cap_check("shadow_same_cycle", 1, 16'h0003);

    // Write gating: closed window blocks NTBL but not the ctrl register.
    wr('h801, 0, 1'b1);
    wr('h802, 0, 1'b1);
    fs();
    wr('h405, 'h00, 1'b0);
    for (int x = 40; x < 48; x++) px(x, 0);
    wr('h803, 0, 1'b0);
    fs();
    cap_start();
    px(0, 7);
    idle(3);
    cap_check("ctrl_closed_r", 1, 16'h0000);
    chk("ctrl_closed_opaque", (cap_o.size() > 0) ? cap_o[0] : 1'bx, 0);

    // Reset with the pipeline full, then enable must be rewritten and latched.
    wr('h803, 1, 1'b1);
    fs();
    for (int x = 0; x < 4; x++) px(x, 7);
    in_valid = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wr('h803, 1, 1'b1);
    cap_start();
    for (int x = 0; x < 4; x++) px(x, 7);
    idle(3);
    capture = 0;
    for (int i = 0; i < cap_o.size(); i++) chk("post_rst_opaque", cap_o[i], 0);
    fs();
    cap_start();
    px(1, 7);
    idle(3);
    capture = 0;
    chk("post_fs_opaque", (cap_o.size() > 0) ? cap_o[0] : 1'bx, 1);

    // Randomized traffic with register writes, closed-window memory writes and frame_start.
    for (int n = 0; n < 600; n++) begin
      int k;
      in_valid    = ($urandom_range(0, 9) < 7);
      xp          = 8'($urandom_range(0, 255));
      yp          = 8'($urandom_range(0, 255));
      frame_start = ($urandom_range(0, 19) == 0);
      k = $urandom_range(0, 19);
      write_enable = (k < 3);
      writable     = 1'b0;
      data         = 8'($urandom_range(0, 255));
      if (k == 0) address = 12'('h200 + $urandom_range(0, 1535));
      else        address = 12'('h800 + $urandom_range(0, 3));
      tick();
    end
    frame_start = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/background_scroll_renderer.md
Name: background_scroll_renderer

Overview:
- Next-generation background tile renderer. Adds hardware fine/coarse scrolling with wrap-around, a full 32x32 nametable, and a frame-synchronised shadow register set.
- Uses synchronous-read (block-RAM friendly) pattern and nametable memories behind a fixed 3-stage pixel pipeline.
- Outputs an opaque flag for sprite compositing.
- Sits between video timing and the pixel mixer; written over the VRAM byte bus.

Parameters:
- ADDR_W, 12, VRAM address width.
- PMB_BASE, 12'h200, base of pattern memory: 32 patterns x 8 rows x 2 bytes = 512 B.
- NTBL_BASE, 12'h400, base of nametable: 32x32 tile bytes = 1024 B.
- REG_BASE, 12'h800, base of the 4-byte register block.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-low reset
- xp  in  8  screen pixel x
- yp  in  8  screen pixel y
- in_valid  in  1  xp/yp is a visible pixel this cycle
- frame_start  in  1  one-cycle pulse at the start of vblank; loads shadow registers
- writable  in  1  VRAM write window open
- data  in  8  write data
- address  in  ADDR_W  write address
- write_enable  in  1  write strobe
- r  out  2  red intensity
- g  out  2  green intensity
- b  out  2  blue intensity
- opaque  out  1  pixel value non-zero and layer enabled
- out_valid  out  1  r/g/b/opaque valid

Behaviour:
- One clock (clk). Reset is synchronous and active-low on rst.
- On reset:
  - r, g, b, opaque and out_valid = 0.
  - Pipeline valid bits = 0.
  - Shadow and active registers = 0: colors 0, scroll 0, enable 0.
  - PMB and NTBL contents are not reset.
- Memory writes:
  - Occur on a clk edge with write_enable && writable.
  - PMB_BASE..+1FF writes PMB byte (address - PMB_BASE).
  - NTBL_BASE..+3FF writes NTBL byte.
- Register writes:
  - Occur on a clk edge with write_enable, regardless of writable.
  - REG_BASE+0: colors, [2:0] color0 RGB, [5:3] color1 RGB.
  - REG_BASE+1: scroll_x.
  - REG_BASE+2: scroll_y.
  - REG_BASE+3: ctrl, bit0 = enable.
  - All other addresses are ignored.
- Shadow/active registers:
  - Writes land in the shadow set. The active set copies the shadow set on frame_start.
  - If a register write and frame_start occur in the same cycle, the active set takes the newly written value.
- Pipeline, for inputs in cycle n:
  - S1 (edge n):
    - sx = xp + scroll_x mod 256, sy = yp + scroll_y mod 256.
    - Issue NTBL read at {sy[7:3], sx[7:3]}.
    - Register fx = sx[2:0], fy = sy[2:0], and valid.
  - S2 (edge n+1): from tile byte T:
    - T[7] colorselect, T[6] hflip, T[5] vflip, T[4:0] pattern.
    - row = vflip ? 7 - fy : fy.
    - Issue PMB reads of bytes {pattern, row, 0} and {pattern, row, 1}.
    - Register hflip, color, fx, valid.
  - S3 (edge n+2):
    - line = {byte0, byte1}.
    - i = hflip ? 7 - fx : fx.
    - pixel p = line[2i+1:2i].
    - c = colorselect ? color1 : color0.
    - Register r = p & {2{c[2]}}, g = p & {2{c[1]}}, b = p & {2{c[0]}}.
    - opaque = (p != 0) && enable.
    - out_valid = S2 valid.
  - Outputs are visible in cycle n+3. Fixed latency 3, fully pipelined, one pixel per clock.
- Pipeline gating:
  - If the valid bit is 0 at a stage, S3 drives r = g = b = 0, opaque = 0, out_valid = 0.
  - enable = 0 forces r = g = b = 0 and opaque = 0; out_valid still follows in_valid.
- Wrap-around: sx and sy wrap modulo 256, so row 31 is followed by row 0 and column 31 by column 0. No special-casing.
- Read-during-write to the same memory address returns the old data.
- Reset asserted mid-frame clears the pipeline within the same edge. The first out_valid can rise no earlier than 3 cycles after rst deasserts with in_valid = 1.

Test Plan:
- Unscrolled render:
  - Load pattern 1 rows all 16'hE4E4.
  - NTBL[0] = 8'h01, colors = 8'b000_111, enable = 1, pulse frame_start.
  - Drive xp = 0..7, yp = 0.
  - Expect from cycle 3: pixels 0,1,2,3,0,1,2,3 on r/g/b, white; opaque low on the value-0 pixels.
- Flips:
  - Same tile with T = 8'h41 (hflip): expect sequence 3,2,1,0,3,2,1,0.
  - With T = 8'h21 (vflip) on a pattern whose row 0 = 16'h5555 and row 7 = 16'h0000: yp = 7 yields 1s.
- Scroll wrap:
  - scroll_x = 8'hFC, scroll_y = 8'hF8.
  - xp = 2, yp = 0 must fetch NTBL[{5'd31, 5'd31}] fine-x 6.
  - xp = 4 must fetch NTBL[{5'd31, 5'd0}] fine-x 0.
- Shadow timing:
  - Write scroll_x = 8 mid-frame: output unchanged until after frame_start.
  - Write scroll_x in the same cycle as frame_start: new value used on the next pixel.
- Write gating:
  - write_enable with writable = 0 to NTBL_BASE+5: the NTBL byte is unchanged.
  - The same condition to REG_BASE+3 still updates the shadow ctrl.
- Reset:
  - Assert rst = 0 with the pipeline full: next edge gives out_valid = 0, all outputs 0, enable = 0.
  - After release, opaque stays 0 until enable is rewritten and frame_start pulses.
